// File: rtl/wb_port_arbiter.sv
// Purpose: sole driver of the register-file write port; merges in-order pipeline results with queued multi-cycle results.
// Latency: a grant in cycle N shows up on wb_* in cycle N+1; queued results wait for a cycle with no pipeline write.
// Backpressure: the pipeline never stalls; mc_ready drops while the FIFO is full, and a same-cycle pop does not raise it.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_data,
    input  logic          mc_valid,
    output logic          mc_ready,
    input  logic [AW-1:0] mc_addr,
    input  logic [DW-1:0] mc_data,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_addr_l,
    input  logic [AW-1:0] rd_addr_r,
    output logic          pend_l,
    output logic          pend_r
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage. A valid bit is set on push and cleared on pop or on a kill,
    // so a set bit always marks an occupied entry that still has to be written.
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic pipe_grant;
    logic fifo_empty;
    logic pop;
    logic issue;
    logic push;

    logic [DEPTH-1:0] hit_l;
    logic [DEPTH-1:0] hit_r;

    // Grant decision: a non-zero pipeline write always wins; otherwise the head
    // is popped, and it is written only if it has not been killed.
    always_comb begin
        pipe_grant = pipe_we && (pipe_addr != '0);
        fifo_empty = (count == '0);
        pop        = !pipe_grant && !fifo_empty;
        issue      = pop && ent_vld[head];
        mc_ready   = (count < CW'(DEPTH));
        // Zero-register results complete the handshake but take no entry.
        push       = mc_valid && mc_ready && (mc_addr != '0);
    end

    // Pending-write lookup for ID: any still-valid queued entry aimed at the source.
    always_comb begin
        hit_l = '0;
        hit_r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_l[i] = ent_vld[i] && (ent_addr[i] == rd_addr_l);
            hit_r[i] = ent_vld[i] && (ent_addr[i] == rd_addr_r);
        end
        pend_l = (|hit_l) && (rd_addr_l != '0);
        pend_r = (|hit_r) && (rd_addr_r != '0);
    end

    // FIFO state: kill older entries on a pipeline write, pop, then push.
    // The push assignment comes last so a same-cycle push is never killed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (pipe_grant) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_addr[i] == pipe_addr) begin
                        ent_vld[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                ent_addr[tail] <= mc_addr;
                ent_data[tail] <= mc_data;
                ent_vld[tail]  <= 1'b1;
                tail           <= tail + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Registered write port; address and data hold when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= pipe_grant || issue;
            if (pipe_grant) begin
                wb_addr <= pipe_addr;
                wb_data <= pipe_data;
            end else if (issue) begin
                wb_addr <= ent_addr[head];
                wb_data <= ent_data[head];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Purpose: randomized and directed stimulus for wb_port_arbiter against a queue-based reference model.
// Latency: expected write-port values are queued per driven cycle and compared one cycle later.
// Backpressure: the model decides acceptance from its own occupancy; refused offers are simply dropped.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_addr = '0;
    logic [DW-1:0] pipe_data = '0;
    logic          mc_valid = 1'b0;
    logic          mc_ready;
    logic [AW-1:0] mc_addr = '0;
    logic [DW-1:0] mc_data = '0;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rd_addr_l = '0;
    logic [AW-1:0] rd_addr_r = '0;
    logic          pend_l;
    logic          pend_r;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr_l(rd_addr_l), .rd_addr_r(rd_addr_r),
        .pend_l(pend_l), .pend_r(pend_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            vld;
    } ent_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    ent_t          mq[$];      // model of queued multi-cycle results, oldest first
    wb_t           expq[$];    // scoreboard: expected write port, one per driven cycle
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pend(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].vld && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    task automatic cycle(input bit pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input logic [AW-1:0] rl, input logic [AW-1:0] rr);
        wb_t  e;
        ent_t h;
        bit   ready_m;
        bit   grant;
        @(negedge clk);
        rst = 1'b0;
        pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
        rd_addr_l = rl; rd_addr_r = rr;
        #1;
        ready_m = (mq.size() < DEPTH);
        chk("mc_ready", 64'(mc_ready), 64'(ready_m));
        chk("pend_l", 64'(pend_l), 64'(m_pend(rl)));
        chk("pend_r", 64'(pend_r), 64'(m_pend(rr)));
        grant = pwe && (pa != '0);
        e.we = 1'b0;
        if (grant) begin
            e.we = 1'b1; last_addr = pa; last_data = pd;
            foreach (mq[i]) if (mq[i].addr == pa) mq[i].vld = 1'b0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.vld) begin
                e.we = 1'b1; last_addr = h.addr; last_data = h.data;
            end
        end
        e.addr = last_addr;
        e.data = last_data;
        expq.push_back(e);
        if (mv && ready_m && ma != '0) begin
            h.addr = ma; h.data = md; h.vld = 1'b1;
            mq.push_back(h);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-flight; rst is released by the next cycle() call.
    task automatic do_reset(input logic [AW-1:0] rl, input logic [AW-1:0] rr);
        @(negedge clk);
        rst = 1'b1;
        pipe_we = 1'b0; mc_valid = 1'b0;
        rd_addr_l = rl; rd_addr_r = rr;
        #1;
        chk("rst_wb_we", 64'(wb_we), 64'(0));
        chk("rst_wb_addr", 64'(wb_addr), 64'(0));
        chk("rst_wb_data", 64'(wb_data), 64'(0));
        chk("rst_mc_ready", 64'(mc_ready), 64'(1));
        chk("rst_pend_l", 64'(pend_l), 64'(0));
        chk("rst_pend_r", 64'(pend_r), 64'(0));
        mq.delete();
        expq.delete();
        last_addr = '0;
        last_data = '0;
    endtask

    // Monitor: every cycle out of reset, pop the expected write-port value and compare.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got no expected entry at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    chk("wb_we", 64'(wb_we), 64'(e.we));
                    chk("wb_addr", 64'(wb_addr), 64'(e.addr));
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(0, 0);

        // Plain pipeline write.
        cycle(1, 3, 32'hDEAD, 0, 0, 0, 0, 0);
        idle(1);

        // Queued r7 waits behind three busy pipeline cycles.
        cycle(1, 1, 32'h100, 1, 7, 32'h11, 7, 0);
        cycle(1, 2, 32'h101, 0, 0, 0, 7, 0);
        cycle(1, 2, 32'h102, 0, 0, 0, 7, 7);
        cycle(0, 0, 0, 0, 0, 0, 7, 7);
        idle(1);

        // Fill the FIFO, offer a fifth result while full, then drain.
        for (int i = 0; i < 4; i++) cycle(1, 1, 32'h200 + i, 1, AW'(8 + i), 32'h300 + i, 9, 11);
        cycle(1, 1, 32'h204, 1, 12, 32'h399, 12, 8);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 10, 12);

        // Kill: queued r5 is superseded by a pipeline write to r5.
        cycle(1, 1, 32'h400, 1, 5, 32'hAA, 5, 0);
        cycle(1, 5, 32'hBB, 0, 0, 0, 5, 0);
        cycle(0, 0, 0, 0, 0, 0, 5, 5);
        idle(1);

        // Zero-address traffic: mc push discarded, pipe slot drains the queue.
        cycle(1, 4, 32'h500, 1, 6, 32'h66, 6, 0);
        cycle(1, 0, 32'h501, 1, 0, 32'h77, 6, 0);
        cycle(1, 0, 32'h502, 0, 0, 0, 6, 0);
        idle(1);

        // Reset mid-drain with entries still queued.
        cycle(1, 1, 32'h600, 1, 13, 32'hA1, 0, 0);
        cycle(1, 1, 32'h601, 1, 14, 32'hA2, 0, 0);
        cycle(1, 1, 32'h602, 1, 15, 32'hA3, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 14, 15);
        do_reset(14, 15);
        idle(4);

        // Random traffic over a small address range to provoke kills and hits.
        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 5, AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            if ($urandom_range(0, 499) == 0) do_reset(AW'($urandom_range(0, 7)), 0);
        end
        idle(2);

        @(posedge clk);
        #5;
        chk("scoreboard_drained", 64'(expq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
